// File: rtl/sigdiv_pkg.sv
// Shared types and constants for the sigdiv restoring significand divider.
package sigdiv_pkg;

    localparam int NSIG_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold values 0..nsig+1.
    function automatic int cnt_width(input int nsig);
        return $clog2(nsig + 3);
    endfunction

endpackage

// File: rtl/sigdiv_if.sv
// Request/result bundle for sigdiv; master drives operands, slave returns results.
interface sigdiv_if
    import sigdiv_pkg::*;
#(
    parameter int NSIG = NSIG_DEFAULT
) ();

    logic            start;
    logic [NSIG:0]   a;
    logic [NSIG:0]   b;
    logic            busy;
    logic            done;
    logic [NSIG+1:0] q;
    logic            sticky;
    logic            dz;

    modport master (
        output start, a, b,
        input  busy, done, q, sticky, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, sticky, dz
    );

endinterface

// File: rtl/sigdiv_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module sigdiv_step #(
    parameter int NSIG = 10
) (
    input  logic [NSIG+1:0] i_rem,
    input  logic [NSIG:0]   i_b,
    output logic            o_qbit,
    output logic [NSIG+1:0] o_rem_nxt
);

    logic [NSIG+1:0] w_b_ext;
    logic [NSIG+1:0] w_diff;

    assign w_b_ext   = {1'b0, i_b};
    assign o_qbit    = (i_rem >= w_b_ext);
    assign w_diff    = o_qbit ? (i_rem - w_b_ext) : i_rem;
    // After a restoring step the remainder is below b, so the top bit is free to drop.
    assign o_rem_nxt = {w_diff[NSIG:0], 1'b0};

endmodule

// File: rtl/sigdiv.sv
// Multi-cycle restoring divider for floating-point significands: q = floor(a*2^(NSIG+1)/b).
// Define SIGDIV_STICKY_EN to build the final-remainder sticky detect; otherwise sticky is 0.
module sigdiv
    import sigdiv_pkg::*;
#(
    parameter int NSIG = NSIG_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    sigdiv_if.slave  bus
);

    localparam int              CW   = cnt_width(NSIG);
    localparam logic [CW-1:0]   LAST = CW'(NSIG + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSIG+1:0] r_rem;
    logic [NSIG:0]   r_b;
    logic [NSIG+1:0] r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_dz;

    logic            w_accept;
    logic            w_b_zero;
    logic            w_last;
    logic            w_qbit;
    logic [NSIG+1:0] w_rem_nxt;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_b_zero = (bus.b == '0);
    assign w_last   = (r_cnt == LAST);

    sigdiv_step #(.NSIG(NSIG)) u_step (
        .i_rem     (r_rem),
        .i_b       (r_b),
        .o_qbit    (w_qbit),
        .o_rem_nxt (w_rem_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_b   <= bus.b;
            r_cnt <= '0;
            r_dz  <= w_b_zero;
            if (w_b_zero) begin
                r_q   <= '1;
                r_rem <= '0;
            end else begin
                r_q   <= '0;
                r_rem <= {1'b0, bus.a};
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[NSIG:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef SIGDIV_STICKY_EN
    logic r_sticky;

    // Captured from the remainder produced by the final step, held with q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_sticky <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_sticky <= |w_rem_nxt;
        end
    end

    assign bus.sticky = r_sticky;
`else
    assign bus.sticky = 1'b0;
`endif

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.q    = r_q;
    assign bus.dz   = r_dz;

endmodule
